// File: rtl/johnson_phase_decoder.sv
// Checks a 4-bit switch-tail ring code sample by sample, decodes its phase, and tracks
// lock with a HUNT/CHECK/LOCKED FSM plus a saturating error counter.
module johnson_phase_decoder #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned MISS_N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] jc,
  output logic [2:0] phase,
  output logic       valid,
  output logic       lock,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0] LockN = LOCK_N[3:0];
  localparam logic [3:0] MissN = MISS_N[3:0];

  logic [1:0] state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [3:0] xcnt_q, xcnt_d;
  logic [3:0] prev_q, prev_d;
  logic [2:0] phase_q, phase_d;
  logic       valid_q, valid_d;
  logic       lock_q, lock_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       legal;
  logic [2:0] dec;
  logic       match;
  logic [3:0] mcnt_inc;
  logic [3:0] xcnt_inc;

  always_comb begin
    legal = 1'b1;
    dec   = 3'd0;
    case (jc)
      4'b0000: dec = 3'd0;
      4'b1000: dec = 3'd1;
      4'b1100: dec = 3'd2;
      4'b1110: dec = 3'd3;
      4'b1111: dec = 3'd4;
      4'b0111: dec = 3'd5;
      4'b0011: dec = 3'd6;
      4'b0001: dec = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // A ring code is never its own successor, so a repeated sample always mismatches.
  assign match    = (jc == {~prev_q[0], prev_q[3:1]});
  assign mcnt_inc = mcnt_q + 4'd1;
  assign xcnt_inc = xcnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    mcnt_d    = mcnt_q;
    xcnt_d    = xcnt_q;
    prev_d    = prev_q;
    phase_d   = phase_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (en) begin
      prev_d  = jc;
      valid_d = legal;
      if (legal) phase_d = dec;
      case (state_q)
        HUNT: begin
          if (legal) begin
            state_d = CHECK;
            mcnt_d  = 4'd1;
          end
        end
        CHECK: begin
          if (match) begin
            mcnt_d = mcnt_inc;
            if (mcnt_inc == LockN) begin
              state_d = LOCKED;
              xcnt_d  = 4'd0;
            end
          end else if (legal) begin
            mcnt_d = 4'd1;
          end else begin
            state_d = HUNT;
            mcnt_d  = 4'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            xcnt_d = 4'd0;
          end else begin
            err_d = 1'b1;
            if (xcnt_inc == MissN) begin
              state_d = HUNT;
              mcnt_d  = 4'd0;
              xcnt_d  = 4'd0;
            end else begin
              xcnt_d = xcnt_inc;
            end
          end
        end
        default: begin
          state_d = HUNT;
          mcnt_d  = 4'd0;
          xcnt_d  = 4'd0;
        end
      endcase
      if (err_d && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
    end
    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      mcnt_q    <= 4'd0;
      xcnt_q    <= 4'd0;
      prev_q    <= 4'd0;
      phase_q   <= 3'd0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      mcnt_q    <= mcnt_d;
      xcnt_q    <= xcnt_d;
      prev_q    <= prev_d;
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign phase   = phase_q;
  assign valid   = valid_q;
  assign lock    = lock_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder (LOCK_N=4, MISS_N=2).
// Observed word is {valid, phase, lock, err, err_cnt}.
module tb_johnson_phase_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] jc  = 4'b0000;
  logic [2:0] phase;
  logic       valid, lock, err;
  logic [7:0] err_cnt;
  logic [13:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  johnson_phase_decoder #(.LOCK_N(4), .MISS_N(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .jc      (jc),
    .phase   (phase),
    .valid   (valid),
    .lock    (lock),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;
  assign obs = {valid, phase, lock, err, err_cnt};

  task automatic step(input logic e, input logic [3:0] c);
    en = e;
    jc = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (obs !== 14'd0) begin
      n_fail++;
      $display("FAIL reset got=%b exp=%b", obs, 14'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_acquire();
    logic [3:0]  js [5] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic [13:0] ex [5] = '{{1'b1, 3'd0, 1'b0, 1'b0, 8'd0}, {1'b1, 3'd1, 1'b0, 1'b0, 8'd0},
                            {1'b1, 3'd2, 1'b0, 1'b0, 8'd0}, {1'b1, 3'd3, 1'b1, 1'b0, 8'd0},
                            {1'b1, 3'd4, 1'b1, 1'b0, 8'd0}};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, js[i]);
      n_tests++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL acquire[%0d] got=%b exp=%b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  js [5] = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
    logic [13:0] ex [5] = '{{1'b1, 3'd5, 1'b1, 1'b0, 8'd0}, {1'b1, 3'd6, 1'b1, 1'b0, 8'd0},
                            {1'b1, 3'd7, 1'b1, 1'b0, 8'd0}, {1'b1, 3'd0, 1'b1, 1'b0, 8'd0},
                            {1'b1, 3'd1, 1'b1, 1'b0, 8'd0}};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, js[i]);
      n_tests++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL wrap[%0d] got=%b exp=%b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_miss_twice();
    logic        es [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  js [4] = '{4'b1100, 4'b0110, 4'b1111, 4'b0000};
    logic [13:0] ex [4] = '{{1'b1, 3'd2, 1'b1, 1'b0, 8'd0}, {1'b0, 3'd2, 1'b1, 1'b1, 8'd1},
                            {1'b1, 3'd4, 1'b0, 1'b1, 8'd2}, {1'b0, 3'd4, 1'b0, 1'b0, 8'd2}};
    for (int i = 0; i < 4; i++) begin
      step(es[i], js[i]);
      n_tests++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL miss_twice[%0d] got=%b exp=%b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_single_miss();
    logic [3:0]  pre [11] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111,
                              4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100};
    logic [3:0]  js [4] = '{4'b1111, 4'b0111, 4'b0111, 4'b0011};
    logic [13:0] ex [4] = '{{1'b1, 3'd4, 1'b1, 1'b1, 8'd1}, {1'b1, 3'd5, 1'b1, 1'b0, 8'd1},
                            {1'b1, 3'd5, 1'b1, 1'b1, 8'd2}, {1'b1, 3'd6, 1'b1, 1'b0, 8'd2}};
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, pre[i]);
    n_tests++;
    if (obs !== {1'b1, 3'd2, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL single_miss_pre got=%b exp=%b", obs, {1'b1, 3'd2, 1'b1, 1'b0, 8'd0});
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, js[i]);
      n_tests++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL single_miss[%0d] got=%b exp=%b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_en_gap();
    logic        es [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0]  js [9] = '{4'b0000, 4'b0110, 4'b1111, 4'b1000, 4'b0000, 4'b1100, 4'b1110,
                            4'b0001, 4'b1111};
    logic [13:0] ex [9] = '{{1'b1, 3'd0, 1'b0, 1'b0, 8'd0}, {1'b0, 3'd0, 1'b0, 1'b0, 8'd0},
                            {1'b0, 3'd0, 1'b0, 1'b0, 8'd0}, {1'b1, 3'd1, 1'b0, 1'b0, 8'd0},
                            {1'b0, 3'd1, 1'b0, 1'b0, 8'd0}, {1'b1, 3'd2, 1'b0, 1'b0, 8'd0},
                            {1'b1, 3'd3, 1'b1, 1'b0, 8'd0}, {1'b0, 3'd3, 1'b1, 1'b0, 8'd0},
                            {1'b1, 3'd4, 1'b1, 1'b0, 8'd0}};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(es[i], js[i]);
      n_tests++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL en_gap[%0d] got=%b exp=%b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_rst_priority();
    logic [3:0]  js [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic [13:0] ex [4] = '{{1'b1, 3'd1, 1'b0, 1'b0, 8'd0}, {1'b1, 3'd2, 1'b0, 1'b0, 8'd0},
                            {1'b1, 3'd3, 1'b0, 1'b0, 8'd0}, {1'b1, 3'd4, 1'b1, 1'b0, 8'd0}};
    // Enters locked at phase 4; assert reset mid-cycle.
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== 14'd0) begin
      n_fail++;
      $display("FAIL rst_async got=%b exp=%b", obs, 14'd0);
    end
    step(1'b1, 4'b0111);
    n_tests++;
    if (obs !== 14'd0) begin
      n_fail++;
      $display("FAIL rst_priority got=%b exp=%b", obs, 14'd0);
    end
    rst = 1'b0;
    step(1'b0, 4'b0000);
    n_tests++;
    if (obs !== 14'd0) begin
      n_fail++;
      $display("FAIL rst_release got=%b exp=%b", obs, 14'd0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, js[i]);
      n_tests++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL reacquire[%0d] got=%b exp=%b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] js [6] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b0110, 4'b0110};
    int exp_cnt;
    do_reset();
    for (int k = 0; k < 150; k++) begin
      for (int i = 0; i < 6; i++) step(1'b1, js[i]);
      exp_cnt = (2 * (k + 1) > 255) ? 255 : 2 * (k + 1);
      n_tests++;
      if ({lock, err_cnt} !== {1'b0, exp_cnt[7:0]}) begin
        n_fail++;
        $display("FAIL saturate[%0d] got lock=%b cnt=%0d exp lock=0 cnt=%0d",
                 k, lock, err_cnt, exp_cnt);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b1, js[i]);
    n_tests++;
    if (obs !== {1'b1, 3'd3, 1'b1, 1'b0, 8'd255}) begin
      n_fail++;
      $display("FAIL sat_relock got=%b exp=%b", obs, {1'b1, 3'd3, 1'b1, 1'b0, 8'd255});
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== 14'd0) begin
      n_fail++;
      $display("FAIL sat_async_rst got=%b exp=%b", obs, 14'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_wrap();
    test_miss_twice();
    test_single_miss();
    test_en_gap();
    test_rst_priority();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
